// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full
//   Write-side pointer / full-flag stage of an asynchronous FIFO (write clock domain).
//   Keeps the binary write pointer, exports a registered Gray copy to the read
//   domain, double-flop synchronises the read Gray pointer, and registers full.
//
//   Optional feature macro: WPTR_AFULL_EN adds a registered almost-full output.
//
// Ports
//   clk          in   write-domain clock
//   rst          in   synchronous reset, active high
//   wr_en_i      in   producer write request
//   rptr_gray_i  in   read pointer (Gray, ADDR_W+1 bits), asynchronous
//   wr_ok_o      out  write accepted this cycle (wr_en_i & ~full_o)
//   waddr_o      out  RAM write address
//   wptr_gray_o  out  registered Gray write pointer to the read domain
//   full_o       out  registered full flag
//   werr_o       out  one-cycle pulse: write attempted while full
//   afull_o      out  registered almost-full (WPTR_AFULL_EN only)
module fifo_wptr_full #(
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W:0]   rptr_gray_i,
  output logic              wr_ok_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [ADDR_W:0]   wptr_gray_o,
  output logic              full_o,
  output logic              werr_o
`ifdef WPTR_AFULL_EN
  ,
  output logic              afull_o
`endif
);

  // Reject illegal configurations at elaboration.
  if (ADDR_W < 2 || AFULL_THRESH < 1 || AFULL_THRESH > (2**ADDR_W) - 1) begin : g_bad_cfg
    $error("fifo_wptr_full: illegal ADDR_W/AFULL_THRESH");
  end

  logic [ADDR_W:0] wbin_q, wbin_d;
  logic [ADDR_W:0] wgray_q, wgray_d;
  logic [ADDR_W:0] rq1_q, rq2_q;
  logic            full_q, full_d;
  logic            werr_q, werr_d;
  logic [ADDR_W:0] full_cmp;

  assign wr_ok_o = wr_en_i & ~full_q;

  always_comb begin
    wbin_d  = wbin_q + {{ADDR_W{1'b0}}, wr_ok_o};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    werr_d  = wr_en_i & full_q;
  end

  // Full when the next write pointer is one lap ahead of the synchronised read
  // pointer: in Gray code that means the top two bits inverted, rest equal.
  assign full_cmp = {~rq2_q[ADDR_W:ADDR_W-1], rq2_q[ADDR_W-2:0]};
  assign full_d   = (wgray_d == full_cmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      full_q  <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rptr_gray_i;
      rq2_q   <= rq1_q;
      full_q  <= full_d;
      werr_q  <= werr_d;
    end
  end

  assign waddr_o     = wbin_q[ADDR_W-1:0];
  assign wptr_gray_o = wgray_q;
  assign full_o      = full_q;
  assign werr_o      = werr_q;

`ifdef WPTR_AFULL_EN
  localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W+1)'((2**ADDR_W) - AFULL_THRESH);

  logic [ADDR_W:0] rbin_s;
  logic [ADDR_W:0] used;
  logic            afull_q, afull_d;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDR_W; i++) rbin_s[i] = ^(rq2_q >> i);
  end

  assign used    = wbin_d - rbin_s;
  assign afull_d = (used >= AFULL_LVL);

  always_ff @(posedge clk) begin
    if (rst) afull_q <= 1'b0;
    else     afull_q <= afull_d;
  end

  assign afull_o = afull_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
module tb_fifo_wptr_full;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW:0]   rptr;
  logic          wr_ok;
  logic [AW-1:0] waddr;
  logic [AW:0]   wgray;
  logic          full;
  logic          werr;
`ifdef WPTR_AFULL_EN
  logic          afull;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_wptr_full #(.ADDR_W(AW), .AFULL_THRESH(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en),
    .rptr_gray_i (rptr),
    .wr_ok_o     (wr_ok),
    .waddr_o     (waddr),
    .wptr_gray_o (wgray),
    .full_o      (full),
    .werr_o      (werr)
`ifdef WPTR_AFULL_EN
    ,
    .afull_o     (afull)
`endif
  );

  typedef struct packed {
    logic          rst;
    logic          wr;
    logic [AW:0]   rptr;
    logic          ok_chk;  // check wr_ok before the edge
    logic          ok;
    logic [AW-1:0] waddr;   // expected after the edge
    logic [AW:0]   gray;
    logic          full;
    logic          werr;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [AW:0] rp);
    @(negedge clk);
    rst = r; wr_en = w; rptr = rp;
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.rst, v.wr, v.rptr);
    if (v.ok_chk) chk($sformatf("v%0d wr_ok", idx), {7'd0, wr_ok}, {7'd0, v.ok});
    @(posedge clk); #1;
    chk($sformatf("v%0d waddr", idx), {6'd0, waddr}, {6'd0, v.waddr});
    chk($sformatf("v%0d gray", idx),  {5'd0, wgray}, {5'd0, v.gray});
    chk($sformatf("v%0d full", idx),  {7'd0, full},  {7'd0, v.full});
    chk($sformatf("v%0d werr", idx),  {7'd0, werr},  {7'd0, v.werr});
  endtask

  initial begin
    logic [AW:0] g;
    rst = 1'b1; wr_en = 1'b0; rptr = '0;

    //          rst  wr   rptr    okc  ok   waddr  gray    full werr
    // reset with write requested
    vq.push_back('{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0});
    // fill four slots, full rises with the 4th write
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'b01, 3'b001, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'b10, 3'b011, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'b11, 3'b010, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'b00, 3'b110, 1'b1, 1'b0});
    // write while full: ignored, werr pulses once
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 3'b110, 1'b1, 1'b1});
    vq.push_back('{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 2'b00, 3'b110, 1'b1, 1'b0});
    // read frees one slot: full drops on the 3rd edge
    vq.push_back('{1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 2'b00, 3'b110, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 2'b00, 3'b110, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 2'b00, 3'b110, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 3'b001, 1'b1, 1'b1, 2'b01, 3'b111, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 2'b01, 3'b111, 1'b1, 1'b1});
    // reset mid-fill
    vq.push_back('{1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'b01, 3'b001, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'b10, 3'b011, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'b11, 3'b010, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'b01, 3'b001, 1'b0, 1'b0});

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Wrap: read side follows the exported pointer, so occupancy seen through
    // the synchroniser stays below depth and full never sets.
    drive(1'b1, 1'b0, 3'b000);
    @(posedge clk); #1;
    g = 3'b000;
    for (int k = 0; k < 8; k++) begin
      logic [AW:0] b;
      drive(1'b0, 1'b1, g);
      @(posedge clk); #1;
      b = 3'(k + 1);
      g = b ^ (b >> 1);
      chk($sformatf("wrap%0d gray", k), {5'd0, wgray}, {5'd0, g});
      chk($sformatf("wrap%0d full", k), {7'd0, full}, 8'd0);
    end
    chk("wrap waddr", {6'd0, waddr}, 8'd0);
    chk("wrap gray_end", {5'd0, wgray}, 8'd0);

`ifdef WPTR_AFULL_EN
    // Almost-full with threshold 1 on a depth-4 FIFO: asserts at 3 used.
    drive(1'b1, 1'b0, 3'b000);
    @(posedge clk); #1;
    chk("af rst", {7'd0, afull}, 8'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 3'b000);
      @(posedge clk); #1;
      chk($sformatf("af%0d afull", k), {7'd0, afull}, (k >= 2) ? 8'd1 : 8'd0);
      chk($sformatf("af%0d full", k),  {7'd0, full},  (k == 3) ? 8'd1 : 8'd0);
    end
`endif

    drive(1'b0, 1'b0, rptr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
